// File: rtl/gpmc_master_if.sv
// Request/response port and multiplexed 16-bit GPMC bus of gpmc_master.
// The master modport is the initiator's view; slave is the user/responder side.
interface gpmc_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  logic        GPMC_CLK;
  logic        GPMC_CS;
  logic        GPMC_ADV;
  logic        GPMC_OE;
  logic        GPMC_WE;
  logic        GPMC_DIR;
  logic        GPMC_BE0;
  logic        GPMC_BE1;
  logic [15:0] GPMC_AD_OUT;
  logic        GPMC_AD_OE;
  logic [15:0] GPMC_AD_IN;
  logic        GPMC_WAIT;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_be, GPMC_AD_IN, GPMC_WAIT,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output GPMC_CLK, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE, GPMC_DIR,
    output GPMC_BE0, GPMC_BE1, GPMC_AD_OUT, GPMC_AD_OE
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_be, GPMC_AD_IN, GPMC_WAIT,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  GPMC_CLK, GPMC_CS, GPMC_ADV, GPMC_OE, GPMC_WE, GPMC_DIR,
    input  GPMC_BE0, GPMC_BE1, GPMC_AD_OUT, GPMC_AD_OE
  );
endinterface

// File: rtl/gpmc_master.sv
// Single-word multiplexed-AD GPMC initiator, GPMC_CLK = clk/2, all bus pins registered.
// Define GPMC_MASTER_WAIT_EN to honour GPMC_WAIT with a WAIT_TIMEOUT-bounded extension.
module gpmc_master #(
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  gpmc_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAT, S_WDATA, S_END} state_e;

  typedef struct packed {
    logic        clk;
    logic        cs;
    logic        adv;
    logic        oe;
    logic        we;
    logic        dir;
    logic [1:0]  be_n;
    logic [15:0] ad_out;
    logic        ad_oe;
  } bus_t;

  localparam bus_t BUS_IDLE = '{clk: 1'b0, cs: 1'b1, adv: 1'b1, oe: 1'b1, we: 1'b1,
                                dir: 1'b0, be_n: 2'b11, ad_out: 16'h0000, ad_oe: 1'b0};
  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  bus_t        bus_q, bus_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;

  logic accept;
  logic phase_last;
  logic wait_ext;
  logic wait_to;

  assign accept     = bus.req_valid & ready_q;
  // Last clk of the final GPMC_CLK period of a data phase: where WAIT is judged.
  assign phase_last = ((state_q == S_LAT) || (state_q == S_WDATA)) &&
                      !bus_q.clk && (cnt_q == 4'd0);

`ifdef GPMC_MASTER_WAIT_EN
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_TIMEOUT);
  logic [7:0] wcnt_q;

  assign wait_ext = bus.GPMC_WAIT && (wcnt_q != WAIT_MAX);
  assign wait_to  = bus.GPMC_WAIT && (wcnt_q == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n)                     wcnt_q <= 8'd0;
    else if (state_q == S_ADDR)     wcnt_q <= 8'd0;
    else if (phase_last && wait_ext) wcnt_q <= wcnt_q + 8'd1;
  end
`else
  logic unused_wait;
  assign unused_wait = bus.GPMC_WAIT;
  assign wait_ext    = 1'b0;
  assign wait_to     = 1'b0;
`endif

  // Request payload captured on accept, held for the whole transaction.
  assign we_d    = accept ? bus.req_we    : we_q;
  assign addr_d  = accept ? bus.req_addr  : addr_q;
  assign wdata_d = accept ? bus.req_wdata : wdata_q;
  assign be_d    = accept ? bus.req_be    : be_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    bus_d       = BUS_IDLE;
    bus_d.clk   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_ADDR;
          cnt_d     = 4'd1;
          bus_d.clk = 1'b1;
        end
      end
      default: begin
        bus_d.clk = ~bus_q.clk;
        // Phase changes only at the end of a whole GPMC_CLK period.
        if (!bus_q.clk) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            case (state_q)
              S_ADDR: begin
                state_d = we_q ? S_WDATA : S_LAT;
                cnt_d   = we_q ? 4'd0 : LAT_LAST;
              end
              S_LAT, S_WDATA: begin
                if (!wait_ext) begin
                  state_d     = S_END;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = wait_to;
                  if (state_q == S_LAT) rdata_d = bus.GPMC_AD_IN;
                end
              end
              S_END: begin
                state_d   = S_IDLE;
                bus_d.clk = 1'b0;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase

    case (state_d)
      S_ADDR: begin
        bus_d.cs     = 1'b0;
        bus_d.adv    = 1'b0;
        bus_d.be_n   = ~be_d;
        bus_d.ad_out = addr_d;
        bus_d.ad_oe  = 1'b1;
      end
      S_LAT: begin
        bus_d.cs   = 1'b0;
        bus_d.oe   = 1'b0;
        bus_d.dir  = 1'b1;
        bus_d.be_n = ~be_d;
      end
      S_WDATA: begin
        bus_d.cs     = 1'b0;
        bus_d.we     = 1'b0;
        bus_d.be_n   = ~be_d;
        bus_d.ad_out = wdata_d;
        bus_d.ad_oe  = 1'b1;
      end
      default: ;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      bus_q       <= BUS_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_q       <= bus_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // NOTE: payload registers have no reset; they are always loaded on accept before being used.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.GPMC_CLK    = bus_q.clk;
  assign bus.GPMC_CS     = bus_q.cs;
  assign bus.GPMC_ADV    = bus_q.adv;
  assign bus.GPMC_OE     = bus_q.oe;
  assign bus.GPMC_WE     = bus_q.we;
  assign bus.GPMC_DIR    = bus_q.dir;
  assign bus.GPMC_BE0    = bus_q.be_n[0];
  assign bus.GPMC_BE1    = bus_q.be_n[1];
  assign bus.GPMC_AD_OUT = bus_q.ad_out;
  assign bus.GPMC_AD_OE  = bus_q.ad_oe;

endmodule

// File: tb/tb_gpmc_master.sv
// Directed bench for gpmc_master: a per-transaction phase-table model predicts every
// bus pin each cycle; literal latency/data checks pin the model to the timing table.
module tb_gpmc_master;
  localparam int L = 2;
`ifdef GPMC_MASTER_WAIT_EN
  localparam int TO  = 4;
  localparam bit WEN = 1'b1;
`else
  localparam int TO  = 15;
  localparam bit WEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpmc_master_if bus ();
  gpmc_master #(.RD_LATENCY(L), .WAIT_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [1:0]  be;
    int          wait_until;
  } req_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_s = 1'b0;
  bit cmp_en = 1'b0;

  req_t pend;
  req_t cur;
  bit   cur_active = 1'b0;
  int   cur_t = 0;
  int   cur_mid = 0;
  bit   cur_err = 1'b0;

  logic [15:0] exp_rdata = 16'h0000;
  int          last_rsp_cyc = -1;
  logic [15:0] last_rsp_data = 16'h0000;
  logic        last_rsp_err = 1'b0;
  int          rsp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_s <= rst_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input logic [1:0] be, input int wu);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.be = be; r.wait_until = wu;
    return r;
  endfunction

  // Data-phase length in clk cycles and timeout flag; WAIT is high on offsets below wait_until.
  function automatic void timing(input req_t r, output int mid, output bit err);
    int k;
    k = 0;
    err = 1'b0;
`ifdef GPMC_MASTER_WAIT_EN
    begin
      int base;
      base = r.we ? 6 : 4 + 2 * L;
      while ((base + 2 * k < r.wait_until) && (k < TO)) k++;
      err = (base + 2 * k < r.wait_until);
    end
`endif
    mid = (r.we ? 2 : 2 * L) + 2 * k;
  endfunction

  // Responder: WAIT and read data for the coming cycle; data is correct only on the sample cycle.
  always @(posedge clk) begin : responder
    int o;
    #1;
    o = cyc - cur_t;
    bus.GPMC_WAIT  = cur_active && (o >= 1) && (o < cur.wait_until);
    bus.GPMC_AD_IN = (cur_active && !cur.we && (o == 4 + cur_mid)) ? cur.rdata : ~cur.rdata;
  end

  always @(negedge clk) begin : compare
    int o;
    logic e_clk, e_cs, e_adv, e_oe, e_we, e_dir, e_adoe, e_ready, e_rv, e_err;
    logic [1:0]  e_be;
    logic [15:0] e_ad;
    if (cmp_en) begin
      e_clk = 1'b0; e_cs = 1'b1; e_adv = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_dir = 1'b0;
      e_be = 2'b11; e_ad = 16'h0000; e_adoe = 1'b0; e_ready = rst_s; e_rv = 1'b0; e_err = 1'b0;
      if (!rst_s) begin
        exp_rdata = 16'h0000;
      end else if (cur_active) begin
        o = cyc - cur_t;
        if ((o >= 1) && (o <= 6 + cur_mid)) begin
          e_ready = 1'b0;
          e_clk   = (o % 2 == 1);
          if (o <= 4) begin
            e_cs = 1'b0; e_adv = 1'b0; e_be = ~cur.be; e_ad = cur.addr; e_adoe = 1'b1;
          end else if (o <= 4 + cur_mid) begin
            e_cs = 1'b0; e_be = ~cur.be;
            if (cur.we) begin
              e_we = 1'b0; e_ad = cur.wdata; e_adoe = 1'b1;
            end else begin
              e_oe = 1'b0; e_dir = 1'b1;
            end
          end else if (o == 5 + cur_mid) begin
            e_rv = 1'b1;
            e_err = cur_err;
            if (!cur.we) exp_rdata = cur.rdata;
          end
        end
      end
      check("GPMC_CLK", bus.GPMC_CLK, e_clk);
      check("GPMC_CS", bus.GPMC_CS, e_cs);
      check("GPMC_ADV", bus.GPMC_ADV, e_adv);
      check("GPMC_OE", bus.GPMC_OE, e_oe);
      check("GPMC_WE", bus.GPMC_WE, e_we);
      check("GPMC_DIR", bus.GPMC_DIR, e_dir);
      check("GPMC_BE", {bus.GPMC_BE1, bus.GPMC_BE0}, e_be);
      check("GPMC_AD_OUT", bus.GPMC_AD_OUT, e_ad);
      check("GPMC_AD_OE", bus.GPMC_AD_OE, e_adoe);
      check("req_ready", bus.req_ready, e_ready);
      check("rsp_valid", bus.rsp_valid, e_rv);
      check("rsp_err", bus.rsp_err, e_err);
      check("rsp_rdata", bus.rsp_rdata, exp_rdata);
      if (bus.rsp_valid === 1'b1) begin
        last_rsp_cyc  = cyc;
        last_rsp_data = bus.rsp_rdata;
        last_rsp_err  = bus.rsp_err;
        rsp_count++;
      end
    end
  end

  task automatic present(input req_t r);
    bus.req_valid = 1'b1;
    bus.req_we    = r.we;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_be    = r.be;
    pend          = r;
  endtask

  task automatic await_accept(output int t);
    bit got;
    got = 1'b0;
    t = cyc;
    for (int i = 0; (i < 200) && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        t = cyc;
        cur = pend;
        timing(pend, cur_mid, cur_err);
        cur_t = cyc;
        cur_active = 1'b1;
      end
    end
    check("accept_within_budget", got, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; (i < 200) && (cyc < cur_t + 7 + cur_mid); i++) @(negedge clk);
  endtask

  task automatic run(input req_t r, output int t);
    @(posedge clk); #1;
    present(r);
    await_accept(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    int t, t2;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0000;
    bus.req_wdata = 16'h0000; bus.req_be = 2'b00;
    cur = mk(1'b1, 16'h0000, 16'h0000, 16'h0000, 2'b00, 0);
    pend = cur;
    rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1'b0);
    check("reset_cs", bus.GPMC_CS, 1'b1);
    check("reset_rdata", bus.rsp_rdata, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_ready", bus.req_ready, 1'b1);

    // Full-word write
    run(mk(1'b1, 16'h0040, 16'h1234, 16'h0000, 2'b11, 0), t);
    check("write_rsp_latency", last_rsp_cyc - t, 7);
    check("write_rsp_err", last_rsp_err, 1'b0);

    // Read returning 0xBEEF
    run(mk(1'b0, 16'h0000, 16'h0000, 16'hBEEF, 2'b11, 0), t);
    check("read_rsp_latency", last_rsp_cyc - t, 9);
    check("read_rdata", last_rsp_data, 16'hBEEF);

    // Byte writes / reads
    run(mk(1'b1, 16'h1357, 16'hA5C3, 16'h0000, 2'b01, 0), t);
    run(mk(1'b0, 16'h8001, 16'h0000, 16'h0F0F, 2'b10, 0), t);
    check("read2_rdata", last_rsp_data, 16'h0F0F);

    // WAIT stuck high during a read
    run(mk(1'b0, 16'h0101, 16'h0000, 16'hC0DE, 2'b11, 1000), t);
    check("read_waitstuck_latency", last_rsp_cyc - t, WEN ? 17 : 9);
    check("read_waitstuck_err", last_rsp_err, WEN);
    check("read_waitstuck_rdata", last_rsp_data, 16'hC0DE);

    // WAIT high for three periods
    run(mk(1'b0, 16'h0202, 16'h0000, 16'h6789, 2'b11, 13), t);
    check("read_wait3_latency", last_rsp_cyc - t, WEN ? 15 : 9);
    check("read_wait3_err", last_rsp_err, 1'b0);

    // WAIT stuck high during a write
    run(mk(1'b1, 16'h0303, 16'hFACE, 16'h0000, 2'b11, 1000), t);
    check("write_waitstuck_latency", last_rsp_cyc - t, WEN ? 15 : 7);
    check("write_waitstuck_err", last_rsp_err, WEN);

    // req_valid held across a read: second request accepted exactly when idle
    @(posedge clk); #1;
    present(mk(1'b0, 16'h0022, 16'h0000, 16'h5A5A, 2'b11, 0));
    await_accept(t);
    @(posedge clk); #1;
    present(mk(1'b1, 16'h0033, 16'h7777, 16'h0000, 2'b11, 0));
    await_accept(t2);
    check("held_valid_spacing", t2 - t, 11);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_done();
    check("rsp_count_before_abort", rsp_count, 9);

    // Reset in the middle of a read
    @(posedge clk); #1;
    present(mk(1'b0, 16'h0444, 16'h0000, 16'h1111, 2'b11, 0));
    await_accept(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; (i < 20) && (cyc != t + 6); i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    cur_active = 1'b0;
    @(negedge clk);
    check("abort_cs", bus.GPMC_CS, 1'b1);
    check("abort_clk", bus.GPMC_CLK, 1'b0);
    check("abort_dir", bus.GPMC_DIR, 1'b0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_ready_after_release", bus.req_ready, 1'b1);
    check("abort_no_response", rsp_count, 9);

    // Recovery read after the abort
    run(mk(1'b0, 16'hFFFF, 16'h0000, 16'h1234, 2'b00, 0), t);
    check("recovery_rdata", last_rsp_data, 16'h1234);
    check("rsp_count_final", rsp_count, 10);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
